// File: rtl/subi_result_fifo_if.sv
// Elastic handshake bundle around the subi result FIFO: upstream (ins) and downstream (outs) channels.
// The slave modport is the FIFO side and the master modport is the surrounding dataflow.
interface subi_result_fifo_if #(
  parameter int DATA_TYPE = 32
);
  logic [DATA_TYPE-1:0] ins;
  logic                 ins_valid;
  logic                 ins_ready;
  logic [DATA_TYPE-1:0] outs;
  logic                 outs_valid;
  logic                 outs_ready;

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );
endinterface

// File: rtl/subi_result_fifo.sv
// Registered-output elastic FIFO behind the integer subtractor. ins_ready depends only on
// the occupancy count, so no combinational path runs from outs_ready back into the subtractor.
module subi_result_fifo #(
  parameter int DATA_TYPE = 32,
  parameter int NUM_SLOTS = 4
) (
  input  logic                clk,
  input  logic                rst,
  subi_result_fifo_if.slave   bus
);
  localparam int PW = $clog2(NUM_SLOTS + 1);
  localparam int AW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_SLOTS - 1);
  localparam logic [PW-1:0] FULL = PW'(NUM_SLOTS);

  logic [DATA_TYPE-1:0] r_mem [NUM_SLOTS];
  logic [PW-1:0]        r_head, r_tail, r_count;

  logic          w_push, w_pop, w_ins_ready, w_outs_valid;
  logic [PW-1:0] w_head_nxt, w_tail_nxt;
  logic [AW-1:0] w_head_idx, w_tail_idx;

  assign w_ins_ready  = (r_count != FULL);
  assign w_outs_valid = (r_count != '0);
  assign w_push       = bus.ins_valid & w_ins_ready;
  assign w_pop        = w_outs_valid & bus.outs_ready;

  // Pointers wrap at NUM_SLOTS-1, so depth need not be a power of two
  assign w_head_nxt = (r_head == LAST) ? '0 : r_head + 1'b1;
  assign w_tail_nxt = (r_tail == LAST) ? '0 : r_tail + 1'b1;
  assign w_head_idx = r_head[AW-1:0];
  assign w_tail_idx = r_tail[AW-1:0];

  assign bus.ins_ready  = w_ins_ready;
  assign bus.outs_valid = w_outs_valid;
  assign bus.outs       = r_mem[w_head_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= w_tail_nxt;
      if (w_pop)  r_head <= w_head_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left uncleared on reset; the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (rst && w_push) r_mem[w_tail_idx] <= bus.ins;
  end
endmodule

// File: tb/tb_subi_result_fifo.sv
// Directed bench for subi_result_fifo: a depth-4 instance for the directed scenarios
// and a depth-3 instance for the odd-depth wrap scenario against a queue scoreboard.
module tb_subi_result_fifo;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  subi_result_fifo_if #(.DATA_TYPE(32)) bus4 ();
  subi_result_fifo_if #(.DATA_TYPE(32)) bus3 ();

  subi_result_fifo #(.DATA_TYPE(32), .NUM_SLOTS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  subi_result_fifo #(.DATA_TYPE(32), .NUM_SLOTS(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst = 1'b0;
    bus4.ins = '0; bus4.ins_valid = 1'b0; bus4.outs_ready = 1'b0;
    bus3.ins = '0; bus3.ins_valid = 1'b0; bus3.outs_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (bus4.ins_ready !== 1'b1) begin errors++; $display("FAIL rst_ins_ready got %b exp 1", bus4.ins_ready); end
    checks++; if (bus4.outs_valid !== 1'b0) begin errors++; $display("FAIL rst_outs_valid got %b exp 0", bus4.outs_valid); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus4.ins = 32'hA0 + i; bus4.ins_valid = 1'b1;
      @(negedge clk);
    end
    bus4.ins_valid = 1'b0;
    checks++; if (bus4.outs !== 32'hA0 || bus4.outs_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_head got %h/%b exp a0/1", bus4.outs, bus4.outs_valid); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus4.outs_valid !== 1'b0) begin errors++; $display("FAIL async_rst_outs_valid got %b exp 0", bus4.outs_valid); end
    checks++; if (bus4.ins_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ins_ready got %b exp 1", bus4.ins_ready); end
    @(negedge clk);
    rst = 1'b1;
    checks++; if (bus4.outs_valid !== 1'b0) begin errors++; $display("FAIL post_rst_empty got %b exp 0", bus4.outs_valid); end
    bus4.ins = 32'h11; bus4.ins_valid = 1'b1;
    @(negedge clk);
    bus4.ins_valid = 1'b0;
    checks++; if (bus4.outs_valid !== 1'b1 || bus4.outs !== 32'h11) begin errors++; $display("FAIL post_rst_push got %h/%b exp 11/1", bus4.outs, bus4.outs_valid); end
    bus4.outs_ready = 1'b1;
    @(negedge clk);
    bus4.outs_ready = 1'b0;
    checks++; if (bus4.outs_valid !== 1'b0) begin errors++; $display("FAIL post_rst_drain got %b exp 0", bus4.outs_valid); end
  endtask

  task automatic test_fill();
    bus4.outs_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (bus4.ins_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b exp 1", i, bus4.ins_ready); end
      bus4.ins = i; bus4.ins_valid = 1'b1;
      @(negedge clk);
    end
    checks++; if (bus4.ins_ready !== 1'b0) begin errors++; $display("FAIL fill_full got %b exp 0", bus4.ins_ready); end
    bus4.ins = 32'h5; bus4.ins_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    bus4.ins_valid = 1'b0;
    checks++; if (bus4.ins_ready !== 1'b0 || bus4.outs !== 32'h1) begin errors++; $display("FAIL fill_hold got %b/%h exp 0/1", bus4.ins_ready, bus4.outs); end
  endtask

  task automatic test_drain();
    checks++; if (bus4.ins_ready !== 1'b0) begin errors++; $display("FAIL drain_start_ready got %b exp 0", bus4.ins_ready); end
    bus4.ins_valid = 1'b0; bus4.outs_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (bus4.outs_valid !== 1'b1 || bus4.outs !== i) begin errors++; $display("FAIL drain_word_%0d got %h/%b exp %h/1", i, bus4.outs, bus4.outs_valid, i); end
      @(negedge clk);
      checks++; if (bus4.ins_ready !== 1'b1) begin errors++; $display("FAIL drain_ready_%0d got %b exp 1", i, bus4.ins_ready); end
    end
    bus4.outs_ready = 1'b0;
    checks++; if (bus4.outs_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", bus4.outs_valid); end
  endtask

  task automatic test_stream();
    bus4.ins_valid = 1'b1; bus4.outs_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus4.ins = 32'h100 + i;
      @(negedge clk);
      checks++; if (bus4.outs_valid !== 1'b1 || bus4.outs !== 32'h100 + i || bus4.ins_ready !== 1'b1) begin
        errors++; $display("FAIL stream_%0d got %h/%b/%b exp %h/1/1", i, bus4.outs, bus4.outs_valid, bus4.ins_ready, 32'h100 + i);
      end
    end
    bus4.ins_valid = 1'b0;
    @(negedge clk);
    bus4.outs_ready = 1'b0;
    checks++; if (bus4.outs_valid !== 1'b0) begin errors++; $display("FAIL stream_tail got %b exp 0", bus4.outs_valid); end
  endtask

  task automatic test_full_pop();
    bus4.outs_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus4.ins = 32'h21 + i; bus4.ins_valid = 1'b1;
      @(negedge clk);
    end
    bus4.ins = 32'h25; bus4.ins_valid = 1'b1; bus4.outs_ready = 1'b1;
    checks++; if (bus4.ins_ready !== 1'b0) begin errors++; $display("FAIL fullpop_ready got %b exp 0", bus4.ins_ready); end
    @(negedge clk);
    bus4.outs_ready = 1'b0;
    checks++; if (bus4.ins_ready !== 1'b1 || bus4.outs !== 32'h22) begin errors++; $display("FAIL fullpop_after got %b/%h exp 1/22", bus4.ins_ready, bus4.outs); end
    @(negedge clk);
    bus4.ins_valid = 1'b0;
    checks++; if (bus4.ins_ready !== 1'b0) begin errors++; $display("FAIL fullpop_refill got %b exp 0", bus4.ins_ready); end
    bus4.outs_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus4.outs_valid !== 1'b1 || bus4.outs !== 32'h22 + i) begin errors++; $display("FAIL fullpop_order_%0d got %h exp %h", i, bus4.outs, 32'h22 + i); end
      @(negedge clk);
    end
    bus4.outs_ready = 1'b0;
    checks++; if (bus4.outs_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %b exp 0", bus4.outs_valid); end
  endtask

  task automatic test_wrap();
    logic [31:0] q[$];
    logic [31:0] word = 32'h1000;
    logic push, pop;
    for (int c = 0; c < 1000 + 8; c++) begin
      bus3.ins        = word;
      bus3.ins_valid  = (c < 1000) ? ($urandom_range(0, 99) < 60) : 1'b0;
      bus3.outs_ready = (c < 1000) ? ($urandom_range(0, 99) < 55) : 1'b1;
      checks++; if (bus3.outs_valid !== (q.size() != 0)) begin errors++; $display("FAIL wrap_valid_c%0d got %b exp %b", c, bus3.outs_valid, q.size() != 0); end
      checks++; if (bus3.ins_ready !== (q.size() != 3)) begin errors++; $display("FAIL wrap_ready_c%0d got %b exp %b", c, bus3.ins_ready, q.size() != 3); end
      push = bus3.ins_valid && (q.size() != 3);
      pop  = bus3.outs_ready && (q.size() != 0);
      if (pop) begin
        checks++; if (bus3.outs !== q[0]) begin errors++; $display("FAIL wrap_data_c%0d got %h exp %h", c, bus3.outs, q[0]); end
        void'(q.pop_front());
      end
      if (push) begin
        q.push_back(word);
        word++;
      end
      @(negedge clk);
    end
    bus3.ins_valid = 1'b0; bus3.outs_ready = 1'b0;
    checks++; if (q.size() != 0 || bus3.outs_valid !== 1'b0) begin errors++; $display("FAIL wrap_final got %b left %0d exp 0", bus3.outs_valid, q.size()); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_full_pop();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
